if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_pkg.sv | 18 +
 rtl/if_fetch_unit_fetch_queue.sv | 74 +++++++
 rtl/if_fetch_unit.sv | 169 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, FSM state codes
// and the mask that word-aligns redirect targets.
package if_fetch_unit_pkg;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [31:0] REDIRECT_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IDLE  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_target(input logic [31:0] target);
        return target & REDIRECT_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs between the memory port and IF/ID.
// Head is read combinationally so it can be popped into IF/ID at the same edge.
module if_fetch_unit_fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wr_en;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    // Flush wins over both push and pop so a redirect leaves the queue truly empty.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = push_ok && (wr_ptr_q == PTR_W'(gi));
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_q[i] <= push_data;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one read at a time, queues words, feeds IF/ID.
// Define FETCH_BYPASS_EN to let a word completing into an empty queue go straight to IF/ID.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_read,
    output logic [31:0] imem_addr,
    input  logic        imem_busywait,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam logic [CNT_W-1:0] QDEPTH_C = CNT_W'(QDEPTH);
`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [31:0]      if_id_inst_q, if_id_inst_d;
    logic [31:0]      if_id_pc_q, if_id_pc_d;
    logic [31:0]      if_id_pc4_q, if_id_pc4_d;
    logic             if_id_valid_q, if_id_valid_d;

    logic             rd_complete;
    logic             rd_busy;
    logic             bypass;
    logic             q_push, q_pop, q_full, q_empty;
    logic [63:0]      q_head;
    logic [CNT_W-1:0] q_count;
    logic [31:0]      target;

    // The in-flight address always equals pc_q: pc only moves on completion or idle redirect.
    assign imem_read   = (state_q != IDLE) && !reset;
    assign imem_addr   = pc_q;
    assign rd_complete = imem_read && !imem_busywait;
    assign rd_busy     = imem_read && imem_busywait;
    assign target      = align_target(branch_target);

    if_fetch_unit_fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (branch_taken),
        .push_data ({pc_q, imem_rdata}),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        if_id_inst_d  = if_id_inst_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        q_pop         = 1'b0;
        bypass        = 1'b0;
        if (branch_taken) begin
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            if (!q_empty) begin
                q_pop         = 1'b1;
                if_id_inst_d  = q_head[31:0];
                if_id_pc_d    = q_head[63:32];
                if_id_pc4_d   = q_head[63:32] + 32'd4;
                if_id_valid_d = 1'b1;
            end else if (BYPASS_EN && (state_q == FETCH) && rd_complete) begin
                bypass        = 1'b1;
                if_id_inst_d  = imem_rdata;
                if_id_pc_d    = pc_q;
                if_id_pc4_d   = pc_q + 32'd4;
                if_id_valid_d = 1'b1;
            end else begin
                if_id_inst_d  = NOP_INST;
                if_id_valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        redirect_pc_d = redirect_pc_q;
        q_push        = 1'b0;
        if (branch_taken) begin
            // A read that cannot finish this cycle must be drained before the new target issues.
            if (rd_busy) begin
                state_d       = DRAIN;
                redirect_pc_d = target;
            end else begin
                state_d = FETCH;
                pc_d    = target;
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (rd_complete) begin
                        pc_d = pc_q + 32'd4;
                        if (!bypass) begin
                            q_push = 1'b1;
                            if ((q_count + CNT_W'(1) - CNT_W'(q_pop)) == QDEPTH_C) begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                IDLE: begin
                    if (!q_full) begin
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (rd_complete) begin
                        pc_d    = redirect_pc_q;
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            if_id_inst_q  <= NOP_INST;
            if_id_pc_q    <= 32'd0;
            if_id_pc4_q   <= 32'd4;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            redirect_pc_q <= redirect_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign if_id_inst  = if_id_inst_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; memory returns 0xA0 + address after a programmable wait.
// Expectations follow FETCH_BYPASS_EN when the bench is built with that macro.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 2;
`endif

    logic        clk;
    logic        reset;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic        imem_busywait;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    int       n_cmp;
    int       n_bad;
    int       lat;
    logic [2:0] busy_cnt;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_read     (imem_read),
        .imem_addr     (imem_addr),
        .imem_busywait (imem_busywait),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .if_id_inst    (if_id_inst),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: busy for 'lat' cycles of each read, then completes.
    always @(posedge clk or posedge reset) begin
        if (reset) busy_cnt <= 3'd0;
        else if (imem_read && !imem_busywait) busy_cnt <= 3'd0;
        else if (imem_read) busy_cnt <= busy_cnt + 3'd1;
    end
    assign imem_busywait = imem_read && (int'(busy_cnt) < lat);
    assign imem_rdata    = 32'hA0 + imem_addr;

    function automatic logic [96:0] ifid();
        return {if_id_valid, if_id_pc, if_id_pc4, if_id_inst};
    endfunction

    function automatic logic [96:0] mk(input logic [31:0] pc);
        logic [31:0] p4;
        logic [31:0] ins;
        p4  = pc + 32'd4;
        ins = pc + 32'hA0;
        return {1'b1, pc, p4, ins};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        lat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'd0;
        lat = 0;
        @(negedge clk);
        n_cmp++;
        if (imem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %b want 0", imem_read); end
        n_cmp++;
        if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        n_cmp++;
        if (ifid() !== {1'b0, 32'd0, 32'd4, NOP}) begin
            n_bad++; $display("FAIL reset_ifid: got %h want %h", ifid(), {1'b0, 32'd0, 32'd4, NOP});
        end
        $display("test_reset done");
    endtask

    task automatic test_stream();
        logic [31:0] pcx;
        do_reset();
        n_cmp++;
        if ({imem_read, imem_addr} !== {1'b1, 32'd0}) begin
            n_bad++; $display("FAIL stream_start: got %b/%h want 1/0", imem_read, imem_addr);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if (imem_addr !== 32'(4 * k)) begin
                n_bad++; $display("FAIL stream_addr edge %0d: got %h want %h", k, imem_addr, 32'(4 * k));
            end
            pcx = 32'(4 * (k - FIRST));
            n_cmp++;
            if (k >= FIRST) begin
                if (ifid() !== mk(pcx)) begin
                    n_bad++; $display("FAIL stream_ifid edge %0d: got %h want %h", k, ifid(), mk(pcx));
                end
            end else if (if_id_valid !== 1'b0) begin
                n_bad++; $display("FAIL stream_bubble edge %0d: got %b want 0", k, if_id_valid);
            end
        end
        $display("test_stream done");
    endtask

    task automatic test_busy();
        int seen;
        logic exp_v;
        logic [31:0] exp_pc;
        seen = 0;
        do_reset();
        lat = 3;
        for (int e = 1; e <= 13; e++) begin
            @(negedge clk);
`ifdef FETCH_BYPASS_EN
            exp_v  = (e % 4 == 0);
            exp_pc = 32'(4 * ((e - 4) / 4));
`else
            exp_v  = (e >= 5) && (e % 4 == 1);
            exp_pc = 32'(4 * ((e - 5) / 4));
`endif
            n_cmp++;
            if ({imem_read, imem_addr} !== {1'b1, 32'(4 * (e / 4))}) begin
                n_bad++; $display("FAIL busy_addr edge %0d: got %b/%h want 1/%h", e, imem_read, imem_addr, 32'(4 * (e / 4)));
            end
            n_cmp++;
            if (exp_v) begin
                if (ifid() !== mk(exp_pc)) begin
                    n_bad++; $display("FAIL busy_ifid edge %0d: got %h want %h", e, ifid(), mk(exp_pc));
                end
            end else if ({if_id_valid, if_id_inst} !== {1'b0, NOP}) begin
                n_bad++; $display("FAIL busy_bubble edge %0d: got %b/%h want 0/%h", e, if_id_valid, if_id_inst, NOP);
            end
            if (if_id_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 3) begin n_bad++; $display("FAIL busy_count: got %0d want 3", seen); end
        lat = 0;
        $display("test_busy done");
    endtask

    task automatic test_stall();
        do_reset();
        stall = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk);
            n_cmp++;
            if ({if_id_valid, if_id_inst} !== {1'b0, NOP}) begin
                n_bad++; $display("FAIL stall_hold edge %0d: got %b/%h want 0/%h", e, if_id_valid, if_id_inst, NOP);
            end
            if (e >= 2) begin
                n_cmp++;
                if ({imem_read, imem_addr} !== {1'b0, 32'h8}) begin
                    n_bad++; $display("FAIL stall_idle edge %0d: got %b/%h want 0/8", e, imem_read, imem_addr);
                end
            end
        end
        stall = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifid() !== mk(32'h0)) begin n_bad++; $display("FAIL stall_q0: got %h want %h", ifid(), mk(32'h0)); end
        @(negedge clk);
        n_cmp++;
        if (ifid() !== mk(32'h4)) begin n_bad++; $display("FAIL stall_q1: got %h want %h", ifid(), mk(32'h4)); end
        n_cmp++;
        if ({imem_read, imem_addr} !== {1'b1, 32'h8}) begin
            n_bad++; $display("FAIL stall_refetch: got %b/%h want 1/8", imem_read, imem_addr);
        end
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'h8)) begin n_bad++; $display("FAIL stall_e8: got %h want %h", ifid(), mk(32'h8)); end
`else
        if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL stall_e8: got %b want 0", if_id_valid); end
`endif
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'hC)) begin n_bad++; $display("FAIL stall_e9: got %h want %h", ifid(), mk(32'hC)); end
`else
        if (ifid() !== mk(32'h8)) begin n_bad++; $display("FAIL stall_e9: got %h want %h", ifid(), mk(32'h8)); end
`endif
        $display("test_stall done");
    endtask

    // Leaves the DUT in DRAIN with a read to 0x10 still busy, redirect target 0x100.
    task automatic enter_drain();
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL drain_pre_addr: got %h want 10", imem_addr); end
        lat = 3;
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'h103;
        @(negedge clk);
        branch_taken = 1'b0;
        n_cmp++;
        if ({imem_read, imem_addr, if_id_valid, if_id_inst} !== {1'b1, 32'h10, 1'b0, NOP}) begin
            n_bad++; $display("FAIL drain_redirect: got %b/%h/%b/%h want 1/10/0/%h", imem_read, imem_addr, if_id_valid, if_id_inst, NOP);
        end
    endtask

    task automatic test_redirect_drain();
        enter_drain();
        @(negedge clk);
        n_cmp++;
        if ({imem_addr, if_id_valid, if_id_inst} !== {32'h10, 1'b0, NOP}) begin
            n_bad++; $display("FAIL drain_hold: got %h/%b/%h want 10/0/%h", imem_addr, if_id_valid, if_id_inst, NOP);
        end
        lat = 0;
        @(negedge clk);
        n_cmp++;
        if ({imem_read, imem_addr, if_id_valid} !== {1'b1, 32'h100, 1'b0}) begin
            n_bad++; $display("FAIL drain_target: got %b/%h/%b want 1/100/0", imem_read, imem_addr, if_id_valid);
        end
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'h100)) begin n_bad++; $display("FAIL drain_e9: got %h want %h", ifid(), mk(32'h100)); end
`else
        if ({if_id_valid, if_id_inst} !== {1'b0, NOP}) begin n_bad++; $display("FAIL drain_e9: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
`endif
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'h104)) begin n_bad++; $display("FAIL drain_e10: got %h want %h", ifid(), mk(32'h104)); end
`else
        if (ifid() !== mk(32'h100)) begin n_bad++; $display("FAIL drain_e10: got %h want %h", ifid(), mk(32'h100)); end
`endif
        $display("test_redirect_drain done");
    endtask

    task automatic test_redirect_stall_complete();
        do_reset();
        repeat (2) @(negedge clk);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        stall = 1'b0;
        branch_taken = 1'b0;
        n_cmp++;
        if ({imem_read, imem_addr, if_id_valid, if_id_inst} !== {1'b1, 32'h40, 1'b0, NOP}) begin
            n_bad++; $display("FAIL rsc_redirect: got %b/%h/%b/%h want 1/40/0/%h", imem_read, imem_addr, if_id_valid, if_id_inst, NOP);
        end
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'h40)) begin n_bad++; $display("FAIL rsc_e4: got %h want %h", ifid(), mk(32'h40)); end
`else
        if ({if_id_valid, if_id_inst} !== {1'b0, NOP}) begin n_bad++; $display("FAIL rsc_e4: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
`endif
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'h44)) begin n_bad++; $display("FAIL rsc_e5: got %h want %h", ifid(), mk(32'h44)); end
`else
        if (ifid() !== mk(32'h40)) begin n_bad++; $display("FAIL rsc_e5: got %h want %h", ifid(), mk(32'h40)); end
`endif
        $display("test_redirect_stall_complete done");
    endtask

    task automatic test_wrap();
        do_reset();
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        @(negedge clk);
        branch_taken = 1'b0;
        n_cmp++;
        if ({imem_read, imem_addr, if_id_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) begin
            n_bad++; $display("FAIL wrap_target: got %b/%h/%b want 1/fffffffc/0", imem_read, imem_addr, if_id_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        @(negedge clk);
        n_cmp++;
`ifdef FETCH_BYPASS_EN
        if (ifid() !== mk(32'h0)) begin n_bad++; $display("FAIL wrap_ifid: got %h want %h", ifid(), mk(32'h0)); end
`else
        if (ifid() !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h9C}) begin
            n_bad++; $display("FAIL wrap_ifid: got %h want %h", ifid(), {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h9C});
        end
`endif
        $display("test_wrap done");
    endtask

    task automatic test_reset_mid_drain();
        enter_drain();
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({imem_read, imem_addr} !== {1'b0, 32'h0}) begin
            n_bad++; $display("FAIL rmd_mem: got %b/%h want 0/0", imem_read, imem_addr);
        end
        n_cmp++;
        if (ifid() !== {1'b0, 32'd0, 32'd4, NOP}) begin
            n_bad++; $display("FAIL rmd_ifid: got %h want %h", ifid(), {1'b0, 32'd0, 32'd4, NOP});
        end
        lat = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({imem_read, imem_addr} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL rmd_restart: got %b/%h want 1/0", imem_read, imem_addr);
        end
        for (int e = 1; e <= 2; e++) begin
            @(negedge clk);
            n_cmp++;
            if (e >= FIRST) begin
                if (ifid() !== mk(32'(4 * (e - FIRST)))) begin
                    n_bad++; $display("FAIL rmd_first edge %0d: got %h want %h", e, ifid(), mk(32'(4 * (e - FIRST))));
                end
            end else if (if_id_valid !== 1'b0) begin
                n_bad++; $display("FAIL rmd_first edge %0d: got %b want 0", e, if_id_valid);
            end
        end
        $display("test_reset_mid_drain done");
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_stream();
        test_busy();
        test_stall();
        test_redirect_drain();
        test_redirect_stall_complete();
        test_wrap();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
